// File: rtl/seg_capture.sv
// seg_capture: samples a multiplexed 4-digit 7-segment bus, decodes each digit back
// to a hex nibble, republishes the 16-bit word and flags malformed bus activity.
module seg_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter bit SEG_LAG       = 1'b1,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic        clk_main,
  input  logic        rst_n,
  input  logic [3:0]  anodes_in,
  input  logic [6:0]  segments_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        seg_err,
  output logic        anode_err,
  output logic        seq_err
);
  localparam logic [0:0] ST_HUNT    = 1'b0;
  localparam logic [0:0] ST_CAPTURE = 1'b1;
  localparam logic [3:0] CNT_MAX    = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0] CNT_PRE    = 4'(STABLE_CYCLES - 2);
  localparam logic [3:0] AN_FIRST   = 4'b0001;

  // Returns {valid, nibble}; valid is clear for any pattern outside the hex font.
  function automatic logic [4:0] f_decode(input logic [6:0] seg);
    case (seg)
      7'h3F:   f_decode = {1'b1, 4'h0};
      7'h06:   f_decode = {1'b1, 4'h1};
      7'h5B:   f_decode = {1'b1, 4'h2};
      7'h4F:   f_decode = {1'b1, 4'h3};
      7'h66:   f_decode = {1'b1, 4'h4};
      7'h6D:   f_decode = {1'b1, 4'h5};
      7'h7D:   f_decode = {1'b1, 4'h6};
      7'h07:   f_decode = {1'b1, 4'h7};
      7'h7F:   f_decode = {1'b1, 4'h8};
      7'h6F:   f_decode = {1'b1, 4'h9};
      7'h77:   f_decode = {1'b1, 4'hA};
      7'h7C:   f_decode = {1'b1, 4'hB};
      7'h39:   f_decode = {1'b1, 4'hC};
      7'h5E:   f_decode = {1'b1, 4'hD};
      7'h79:   f_decode = {1'b1, 4'hE};
      7'h71:   f_decode = {1'b1, 4'hF};
      default: f_decode = 5'b0_0000;
    endcase
  endfunction

  logic [10:0] w_bus_in, r_sync1, r_sync2, r_hist, r_last_acc;
  logic [3:0]  r_cnt, r_mask, w_mask_nx, r_prev, w_prev_nx, w_anode, w_target;
  logic [0:0]  r_state, w_state_nx;
  logic [6:0]  w_seg;
  logic [4:0]  w_dec;
  logic [15:0] r_shadow, w_shadow_nx;
  logic        w_strike, w_accept, w_onehot, w_in_order, w_write;
  logic        w_pub_nx, w_aerr_nx, w_serr_nx, w_qerr_nx, r_pub;

  assign w_bus_in = {anodes_in, segments_in} ^ {11{ACTIVE_LOW}};
  // A pair already accepted is not re-accepted after a glitch restores it.
  assign w_strike = (r_sync2 == r_hist) && (r_cnt == CNT_PRE);
  assign w_accept = w_strike && (r_sync2 != r_last_acc);

  // Synchronizer and stability filter.
  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 11'd0;
      r_sync2    <= 11'd0;
      r_hist     <= 11'd0;
      r_last_acc <= 11'd0;
      r_cnt      <= 4'd0;
    end else begin
      r_sync1 <= w_bus_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      if (r_sync2 != r_hist) begin
        r_cnt <= 4'd0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 4'd1;
      end else begin
        r_cnt <= r_cnt;
      end
      r_last_acc <= w_strike ? r_sync2 : r_last_acc;
    end
  end

  // Frame tracking: order checks, decode into the shadow word, completion detect.
  always_comb begin
    w_anode     = r_sync2[10:7];
    w_seg       = r_sync2[6:0];
    w_onehot    = (w_anode != 4'd0) && ((w_anode & (w_anode - 4'd1)) == 4'd0);
    w_dec       = f_decode(w_seg);
    w_target    = SEG_LAG ? r_prev : w_anode;
    w_in_order  = (w_anode == {r_prev[2:0], r_prev[3]});
    w_state_nx  = r_state;
    w_mask_nx   = r_mask;
    w_shadow_nx = r_shadow;
    w_prev_nx   = r_prev;
    w_write     = 1'b0;
    w_pub_nx    = 1'b0;
    w_aerr_nx   = 1'b0;
    w_serr_nx   = 1'b0;
    w_qerr_nx   = 1'b0;
    if (!w_accept) begin
      w_write = 1'b0;
    end else if (!w_onehot) begin
      w_aerr_nx  = 1'b1;
      w_state_nx = ST_HUNT;
      w_mask_nx  = 4'd0;
      w_prev_nx  = 4'd0;
    end else begin
      w_prev_nx = w_anode;
      // On frame entry a lagged segment belongs to the pre-frame digit and is dropped.
      if (r_state == ST_HUNT) begin
        if (w_anode == AN_FIRST) begin
          w_state_nx = ST_CAPTURE;
          w_mask_nx  = 4'd0;
          w_write    = !SEG_LAG;
        end else begin
          w_write = 1'b0;
        end
      end else if (w_in_order) begin
        w_write = 1'b1;
      end else if (w_anode == AN_FIRST) begin
        w_mask_nx = 4'd0;
        w_write   = !SEG_LAG;
      end else begin
        w_qerr_nx  = 1'b1;
        w_state_nx = ST_HUNT;
        w_mask_nx  = 4'd0;
      end
    end
    if (w_write && (w_target != 4'd0)) begin
      if (w_dec[4]) begin
        case (w_target)
          4'b0001: w_shadow_nx[11:8]  = w_dec[3:0];
          4'b0010: w_shadow_nx[7:4]   = w_dec[3:0];
          4'b0100: w_shadow_nx[3:0]   = w_dec[3:0];
          4'b1000: w_shadow_nx[15:12] = w_dec[3:0];
          default: w_shadow_nx        = r_shadow;
        endcase
        w_mask_nx = w_mask_nx | w_target;
      end else begin
        w_serr_nx = 1'b1;
      end
    end else begin
      w_serr_nx = 1'b0;
    end
    if (w_mask_nx == 4'hF) begin
      w_pub_nx  = 1'b1;
      w_mask_nx = 4'd0;
    end else begin
      w_pub_nx = 1'b0;
    end
  end

  // State, shadow word and registered outputs.
  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_HUNT;
      r_mask     <= 4'd0;
      r_shadow   <= 16'd0;
      r_prev     <= 4'd0;
      r_pub      <= 1'b0;
      data_out   <= 16'd0;
      data_valid <= 1'b0;
      seg_err    <= 1'b0;
      anode_err  <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_mask     <= w_mask_nx;
      r_shadow   <= w_shadow_nx;
      r_prev     <= w_prev_nx;
      r_pub      <= w_pub_nx;
      data_out   <= r_pub ? r_shadow : data_out;
      data_valid <= r_pub;
      seg_err    <= w_serr_nx;
      anode_err  <= w_aerr_nx;
      seq_err    <= w_qerr_nx;
    end
  end
endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: drives a lagged 7-segment bus into a true-polarity and an
// inverted-polarity seg_capture and compares both against a transaction model.
module tb_seg_capture;
  localparam int HOLD = 20;

  logic        clk_main = 1'b0;
  logic        rst_n    = 1'b0;
  logic [3:0]  an       = 4'd0;
  logic [6:0]  sg       = 7'd0;
  logic [3:0]  an_inv;
  logic [6:0]  sg_inv;
  logic [15:0] dout [2];
  logic        dv [2];
  logic        serr [2];
  logic        aerr [2];
  logic        qerr [2];

  assign an_inv = ~an;
  assign sg_inv = ~sg;

  always #5 clk_main = ~clk_main;

  seg_capture #(.STABLE_CYCLES(4), .SEG_LAG(1'b1), .ACTIVE_LOW(1'b0)) u_dut (
    .clk_main(clk_main), .rst_n(rst_n), .anodes_in(an), .segments_in(sg),
    .data_out(dout[0]), .data_valid(dv[0]), .seg_err(serr[0]),
    .anode_err(aerr[0]), .seq_err(qerr[0]));

  seg_capture #(.STABLE_CYCLES(4), .SEG_LAG(1'b1), .ACTIVE_LOW(1'b1)) u_dut_inv (
    .clk_main(clk_main), .rst_n(rst_n), .anodes_in(an_inv), .segments_in(sg_inv),
    .data_out(dout[1]), .data_valid(dv[1]), .seg_err(serr[1]),
    .anode_err(aerr[1]), .seq_err(qerr[1]));

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: frame state kept as digit positions 0..3 in rotation order.
  bit          m_hunt;
  logic [3:0]  m_mask;
  logic [3:0]  m_nib [4];
  int          m_prev_pos;
  logic [10:0] m_last;
  logic [15:0] exp_data;
  int          e_valid, e_seg, e_anode, e_seq;
  logic [6:0]  lag_seg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_hunt     = 1'b1;
    m_mask     = 4'd0;
    m_prev_pos = -1;
    m_last     = 11'd0;
    exp_data   = 16'd0;
    for (int k = 0; k < 4; k++) m_nib[k] = 4'd0;
  endtask

  task automatic model_step(input logic [3:0] a, input logic [6:0] s);
    int pos;
    int idx;
    e_valid = 0; e_seg = 0; e_anode = 0; e_seq = 0;
    if ({a, s} == m_last) return;
    m_last = {a, s};
    if ($countones(a) != 1) begin
      e_anode = 1; m_hunt = 1'b1; m_mask = 4'd0; m_prev_pos = -1;
      return;
    end
    pos = 0;
    for (int k = 0; k < 4; k++) if (a[k]) pos = k;
    if (m_hunt) begin
      if (pos == 0) begin m_hunt = 1'b0; m_mask = 4'd0; end
    end else if (m_prev_pos >= 0 && pos == (m_prev_pos + 1) % 4) begin
      // the segments seen now are the previous digit's
      idx = -1;
      for (int k = 0; k < 16; k++) if (seg_tab[k] == s) idx = k;
      if (idx < 0) e_seg = 1;
      else begin m_nib[m_prev_pos] = 4'(idx); m_mask[m_prev_pos] = 1'b1; end
      if (m_mask == 4'hF) begin
        e_valid  = 1;
        exp_data = {m_nib[3], m_nib[0], m_nib[1], m_nib[2]};
        m_mask   = 4'd0;
      end
    end else if (pos == 0) begin
      m_mask = 4'd0;
    end else begin
      e_seq = 1; m_hunt = 1'b1; m_mask = 4'd0;
    end
    m_prev_pos = pos;
  endtask

  task automatic step(input logic [3:0] a, input logic [6:0] s, input bit glitch);
    int c_v[2], c_s[2], c_a[2], c_q[2];
    an = a;
    sg = s;
    model_step(a, s);
    for (int d = 0; d < 2; d++) begin c_v[d] = 0; c_s[d] = 0; c_a[d] = 0; c_q[d] = 0; end
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clk_main);
      sg = (glitch && i == 12) ? (s ^ 7'h10) : s;
      for (int d = 0; d < 2; d++) begin
        if (dv[d])   c_v[d]++;
        if (serr[d]) c_s[d]++;
        if (aerr[d]) c_a[d]++;
        if (qerr[d]) c_q[d]++;
      end
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("valid_cnt[%0d] an=%b", d, a), 32'(c_v[d]), 32'(e_valid));
      chk($sformatf("seg_err_cnt[%0d] an=%b", d, a), 32'(c_s[d]), 32'(e_seg));
      chk($sformatf("anode_err_cnt[%0d] an=%b", d, a), 32'(c_a[d]), 32'(e_anode));
      chk($sformatf("seq_err_cnt[%0d] an=%b", d, a), 32'(c_q[d]), 32'(e_seq));
      chk($sformatf("data_out[%0d] an=%b", d, a), 32'(dout[d]), 32'(exp_data));
    end
  endtask

  task automatic drive_digit(input int pos, input logic [6:0] pat, input bit glitch);
    step(4'(1 << pos), lag_seg, glitch);
    lag_seg = pat;
  endtask

  task automatic send_frame(input logic [15:0] w, input int glitch_pos, input int bad_pos,
                            input logic [6:0] bad_pat);
    logic [3:0] nib [4];
    nib[0] = w[11:8]; nib[1] = w[7:4]; nib[2] = w[3:0]; nib[3] = w[15:12];
    for (int p = 0; p < 4; p++)
      drive_digit(p, (p == bad_pos) ? bad_pat : seg_tab[nib[p]], p == glitch_pos);
  endtask

  function automatic logic [6:0] rand_bad_pat();
    logic [6:0] pat;
    bit hit;
    do begin
      pat = 7'($urandom);
      hit = 1'b0;
      for (int k = 0; k < 16; k++) if (seg_tab[k] == pat) hit = 1'b1;
    end while (hit);
    return pat;
  endfunction

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_dout[%0d]", tag, d), 32'(dout[d]), 32'd0);
      chk($sformatf("%s_flags[%0d]", tag, d),
          32'({dv[d], serr[d], aerr[d], qerr[d]}), 32'd0);
    end
  endtask

  initial begin
    model_reset();
    lag_seg = 7'h00;
    repeat (3) @(negedge clk_main);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // clean 1234 frames, then a glitch mid-digit
    send_frame(16'h1234, -1, -1, 7'h00);
    send_frame(16'h1234, -1, -1, 7'h00);
    send_frame(16'h1234, 2, -1, 7'h00);
    // blank pattern on the 0100 slot, then clean frames
    send_frame(16'h5678, -1, 2, 7'h00);
    send_frame(16'h9ABC, -1, -1, 7'h00);
    send_frame(16'hDEF0, -1, -1, 7'h00);
    // out-of-order jump 0010 -> 1000
    drive_digit(0, seg_tab[4'h1], 1'b0);
    drive_digit(1, seg_tab[4'h2], 1'b0);
    drive_digit(3, seg_tab[4'h3], 1'b0);
    send_frame(16'hA5C3, -1, -1, 7'h00);
    send_frame(16'h0F1E, -1, -1, 7'h00);
    // non-one-hot anode
    step(4'b0011, lag_seg, 1'b0);
    send_frame(16'h4321, -1, -1, 7'h00);
    send_frame(16'h8765, -1, -1, 7'h00);

    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 9) == 0) step(4'($urandom_range(0, 15)), lag_seg, 1'b0);
      send_frame(16'($urandom), ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1,
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1, rand_bad_pat());
    end
    send_frame(16'hBEEF, -1, -1, 7'h00);

    // asynchronous reset mid-frame
    drive_digit(0, seg_tab[4'hC], 1'b0);
    drive_digit(1, seg_tab[4'hA], 1'b0);
    @(negedge clk_main);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    model_reset();
    repeat (3) @(negedge clk_main);
    rst_n = 1'b1;
    send_frame(16'hCAFE, -1, -1, 7'h00);
    send_frame(16'h1357, -1, -1, 7'h00);
    send_frame(16'h2468, -1, -1, 7'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
